alu_seq_core: RTL and testbench

Sequential execution core of the Stage-3 ALU. Accepts one operation at a time via a start/busy/valid handshake. Logic, arithmetic and shift ops complete in one cycle; multiply and unsigned divide/remainder run as 32-step iterative sequences. Its registered `result` feeds the 32-bit Y output register directly, so `result` is stable whenever `valid` is high.

---
 rtl/alu_seq_core.sv | 177 +++++++++++++++++
 tb/tb_alu_seq_core.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_core.sv
// alu_seq_core: sequential ALU execution core.
// Logic, arithmetic and shift ops finish in one cycle; MUL, DIVU and REMU run
// WIDTH-step iterative sequences sharing one set of working registers.
module alu_seq_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             valid,
    output logic             busy,
    output logic             err
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;
    localparam logic [3:0] OP_DIVU = 4'd9;
    localparam logic [3:0] OP_REMU = 4'd10;

    localparam logic STATE_IDLE = 1'b0;
    localparam logic STATE_ITER = 1'b1;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    logic             state;
    logic [CNT_W-1:0] step_cnt;
    logic [3:0]       op_q;
    // Working registers. MUL: acc_q = partial product, x_q = multiplicand,
    // y_q = multiplier. DIVU/REMU: acc_q = remainder, x_q = dividend shifting
    // out MSB-first while quotient bits shift in, y_q = divisor.
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;

    logic [WIDTH:0]   add_full;
    logic [WIDTH:0]   sub_full;
    logic [CNT_W-1:0] shamt;
    logic [WIDTH-1:0] sc_result;
    logic             sc_c;
    logic             sc_v;
    logic             sc_err;
    logic             is_iter_op;

    logic [WIDTH-1:0] mul_acc_next;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ok;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quot_next;
    logic [WIDTH-1:0] iter_result;

    assign busy = (state == STATE_ITER);

    // Single-cycle datapath: result and C/V for every op decoded straight from a/b.
    always_comb begin
        // NOTE: every output of a combinational block gets a default up front,
        // so no path through the case can leave a value held (no latch).
        add_full   = {1'b0, a} + {1'b0, b};
        sub_full   = {1'b0, a} - {1'b0, b};
        shamt      = b[CNT_W-1:0];
        sc_result  = '0;
        sc_c       = 1'b0;
        sc_v       = 1'b0;
        sc_err     = 1'b0;
        is_iter_op = 1'b0;
        case (op)
            OP_ADD: begin
                sc_result = add_full[WIDTH-1:0];
                sc_c      = add_full[WIDTH];
                sc_v      = (a[WIDTH-1] == b[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_result = sub_full[WIDTH-1:0];
                sc_c      = ~sub_full[WIDTH];  // carry means "no borrow", i.e. a >= b
                sc_v      = (a[WIDTH-1] != b[WIDTH-1]) && (sub_full[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  sc_result = a & b;
            OP_OR:   sc_result = a | b;
            OP_XOR:  sc_result = a ^ b;
            OP_SLL:  sc_result = a << shamt;
            OP_SRL:  sc_result = a >> shamt;
            OP_SRA:  sc_result = $unsigned($signed(a) >>> shamt);
            OP_MUL, OP_DIVU, OP_REMU: is_iter_op = 1'b1;
            default: sc_err = 1'b1;  // illegal: zero result, Z flag follows from it
        endcase
    end

    // One iteration step: shift-add multiply and restoring-divide next values.
    always_comb begin
        mul_acc_next = acc_q + (y_q[0] ? x_q : '0);
        div_shift    = {acc_q, x_q[WIDTH-1]};
        div_diff     = div_shift - {1'b0, y_q};
        div_ok       = ~div_diff[WIDTH];
        rem_next     = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        quot_next    = {x_q[WIDTH-2:0], div_ok};
        case (op_q)
            OP_MUL:  iter_result = mul_acc_next;
            OP_DIVU: iter_result = quot_next;
            default: iter_result = rem_next;
        endcase
    end

    // Control FSM, iteration registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the working registers are reset too; they are plain flops,
            // not a memory array, so clearing them costs nothing and keeps
            // every state bit known after reset.
            state    <= STATE_IDLE;
            step_cnt <= '0;
            op_q     <= '0;
            acc_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            result   <= '0;
            flags    <= '0;
            valid    <= 1'b0;
            err      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // samples the values from before this edge regardless of order.
            valid <= 1'b0;
            err   <= 1'b0;
            case (state)
                STATE_IDLE: begin
                    if (start) begin
                        if (is_iter_op) begin
                            op_q     <= op;
                            step_cnt <= '0;
                            acc_q    <= '0;
                            x_q      <= a;
                            y_q      <= b;
                            state    <= STATE_ITER;
                        end else begin
                            result <= sc_result;
                            flags  <= {sc_result[WIDTH-1], (sc_result == '0), sc_c, sc_v};
                            valid  <= 1'b1;
                            err    <= sc_err;
                        end
                    end
                end
                default: begin
                    step_cnt <= step_cnt + 1'b1;
                    if (op_q == OP_MUL) begin
                        acc_q <= mul_acc_next;
                        x_q   <= x_q << 1;
                        y_q   <= y_q >> 1;
                    end else begin
                        acc_q <= rem_next;
                        x_q   <= quot_next;
                    end
                    if (step_cnt == LAST_STEP) begin
                        result <= iter_result;
                        flags  <= {iter_result[WIDTH-1], (iter_result == '0), 2'b00};
                        valid  <= 1'b1;
                        state  <= STATE_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_core.sv
// tb_alu_seq_core: directed and randomized checks of alu_seq_core against a
// behavioural model written with plain arithmetic.
module tb_alu_seq_core;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic [3:0]  flags;
    logic        valid;
    logic        busy;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_seq_core #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .result (result),
        .flags  (flags),
        .valid  (valid),
        .busy   (busy),
        .err    (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit is_iter(input logic [3:0] o);
        return (o == 4'd8) || (o == 4'd9) || (o == 4'd10);
    endfunction

    // Reference model: results straight from arithmetic definitions.
    function automatic void ref_model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                      output logic [31:0] r, output logic [3:0] f, output logic e);
        logic [63:0] ux;
        logic [63:0] uy;
        logic [63:0] wide;
        longint      sx;
        longint      sy;
        longint      s;
        longint      lim;
        logic        c;
        logic        v;
        ux  = {32'd0, x};
        uy  = {32'd0, y};
        sx  = $signed(x);
        sy  = $signed(y);
        lim = 64'sd2147483647;
        c = 1'b0;
        v = 1'b0;
        e = 1'b0;
        r = 32'd0;
        case (o)
            4'd0: begin
                wide = ux + uy;
                r = wide[31:0];
                c = wide[32];
                s = sx + sy;
                v = (s > lim) || (s < -lim - 1);
            end
            4'd1: begin
                r = x - y;
                c = (x >= y);
                s = sx - sy;
                v = (s > lim) || (s < -lim - 1);
            end
            4'd2: r = x & y;
            4'd3: r = x | y;
            4'd4: r = x ^ y;
            4'd5: r = x << y[4:0];
            4'd6: r = x >> y[4:0];
            4'd7: begin
                r = x >> y[4:0];
                if (x[31]) r = r | ~(32'hFFFF_FFFF >> y[4:0]);
            end
            4'd8: begin
                wide = ux * uy;
                r = wide[31:0];
            end
            4'd9:  r = (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
            4'd10: r = (y == 32'd0) ? x : x % y;
            default: e = 1'b1;
        endcase
        f = {r[31], (r == 32'd0), c, v};
    endfunction

    // Issue one op at the current negedge, wait for valid and check everything.
    // Returns in the valid cycle (at its negedge).
    task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                          input bit poke, output logic [31:0] r_got, output logic [3:0] f_got);
        logic [31:0] r_exp;
        logic [3:0]  f_exp;
        logic        e_exp;
        int          edges;
        int          busy_cnt;
        ref_model(o, x, y, r_exp, f_exp, e_exp);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        op    = 4'($urandom);
        edges    = 1;
        busy_cnt = 0;
        while (!valid && edges < 64) begin
            if (busy) busy_cnt++;
            start = poke && (edges == 10);
            @(posedge clk);
            @(negedge clk);
            edges++;
        end
        start = 1'b0;
        check("latency",       32'(edges),    is_iter(o) ? 32'd33 : 32'd1);
        check("busy_window",   32'(busy_cnt), is_iter(o) ? 32'd32 : 32'd0);
        check("busy_at_valid", 32'(busy),     32'd0);
        check("result",        result,        r_exp);
        check("flags",         32'(flags),    32'(f_exp));
        check("err",           32'(err),      32'(e_exp));
        r_got = result;
        f_got = flags;
    endtask

    task automatic idle_check();
        @(negedge clk);
        check("valid_pulse", 32'(valid), 32'd0);
        check("err_pulse",   32'(err),   32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic [3:0]  f;
        int          vcount;

        rst   = 1'b1;
        start = 1'b0;
        op    = 4'd0;
        a     = 32'd0;
        b     = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_result", result,       32'd0);
        check("rst_flags",  32'(flags),   32'd0);
        check("rst_valid",  32'(valid),   32'd0);
        check("rst_busy",   32'(busy),    32'd0);
        check("rst_err",    32'(err),     32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Overflowing ADD, then asynchronous reset in the middle of the valid cycle.
        run_op(4'd0, 32'h7FFF_FFFF, 32'd1, 1'b0, r, f);
        check("add_ovf_result", r, 32'h8000_0000);
        check("add_ovf_flags",  32'(f), 32'h9);
        #1 rst = 1'b1;
        #1;
        check("async_rst_result", result,     32'd0);
        check("async_rst_flags",  32'(flags), 32'd0);
        check("async_rst_valid",  32'(valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_op(4'd1, 32'd5, 32'd5, 1'b0, r, f);
        check("sub_eq_result", r, 32'd0);
        check("sub_eq_flags",  32'(f), 32'h6);
        run_op(4'd7, 32'h8000_0000, 32'd4, 1'b0, r, f);
        check("sra_result", r, 32'hF800_0000);

        // MUL with a start pulse mid-op, then an AND issued in the MUL valid cycle.
        run_op(4'd8, 32'h0001_0003, 32'h0000_0005, 1'b1, r, f);
        check("mul_result", r, 32'h0005_000F);
        run_op(4'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0, r, f);
        check("b2b_and_result", r, 32'h00F0_1234);

        run_op(4'd9,  32'd100, 32'd7, 1'b0, r, f);
        check("divu_result", r, 32'd14);
        run_op(4'd10, 32'd100, 32'd7, 1'b0, r, f);
        check("remu_result", r, 32'd2);
        run_op(4'd9,  32'd9, 32'd0, 1'b0, r, f);
        check("divu0_result", r, 32'hFFFF_FFFF);
        run_op(4'd10, 32'd9, 32'd0, 1'b0, r, f);
        check("remu0_result", r, 32'd9);

        run_op(4'd13, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, r, f);
        check("illegal_result", r, 32'd0);
        check("illegal_flags",  32'(f), 32'h4);
        idle_check();

        // Reset during step 10 of a DIVU: the op is abandoned with no valid.
        start = 1'b1;
        op    = 4'd9;
        a     = 32'd1000;
        b     = 32'd3;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("busy_before_abort", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_busy",  32'(busy),  32'd0);
        check("abort_valid", 32'(valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        vcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (valid) vcount++;
        end
        check("abort_no_valid", 32'(vcount), 32'd0);
        run_op(4'd0, 32'd2, 32'd3, 1'b0, r, f);
        check("post_abort_add", r, 32'd5);

        // Randomized ops, including small divisors/shift amounts and illegal codes.
        for (int n = 0; n < 150; n++) begin
            logic [3:0]  ro;
            logic [31:0] rx;
            logic [31:0] ry;
            ro = 4'($urandom_range(0, 15));
            rx = $urandom;
            ry = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom);
            run_op(ro, rx, ry, 1'($urandom_range(0, 1)), r, f);
            if ($urandom_range(0, 1) == 1) idle_check();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
